sram_ctrl_gen: RTL and testbench
================================

# sram_ctrl_gen

Parametrised external-SRAM controller that sits between the MEM stage and the off-chip asynchronous SRAM. It replaces the fixed-latency, fixed-width controller with configurable data width, wait states, base offset and multi-beat reads that assemble a wide line for the cache. Byte-lane writes are supported. An explicit FSM drives the SRAM pins, and the CPU is stalled through `ready`.

## Interface
- `DW`, default 32: SRAM data-bus width in bits; must be a multiple of 8.
- `SRAM_AW`, default 17: SRAM word-address width.
- `BASE_ADDR`, default 1024: CPU byte address that maps to SRAM word 0.
- `WAIT_STATES`, default 3: cycles each beat is held on the bus; must be ≥1.
- `BEATS`, default 2: words fetched per read; `read_data` is `DW*BEATS` wide.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `mem_w_en` input 1: write request, held until `ready`.
- `mem_r_en` input 1: read request, held until `ready`.
- `address` input 32: CPU byte address.
- `write_data` input DW: write word.
- `byte_en` input DW/8: write lane enables.
- `ready` output 1: stall release.
- `read_data` output DW*BEATS: read line; beat 0 is in the LSBs.
- `sram_addr` output SRAM_AW: word address.
- `sram_dq` inout DW: SRAM data bus.
- `sram_we_n`, `sram_oe_n`, `sram_ce_n` output 1 each: active-low strobes.
- `sram_be_n` output DW/8: active-low lane enables.
- `addr_err` output 1: present only with `SRAM_CTRL_RANGE_CHK_EN`.

## Operation
- States are IDLE, WRITE, WREC, READ and DONE.
- IDLE:
  - The controller accepts a request when `mem_w_en` or `mem_r_en` is high.
  - If both are high, the write wins.
  - It latches `word = (address - BASE_ADDR) >> log2(DW/8)`, truncated to `SRAM_AW` bits. Low byte-offset bits are ignored.
  - It also latches `write_data` and `byte_en`.
- WRITE:
  - Lasts `WAIT_STATES` cycles.
  - `sram_we_n`=0, `sram_ce_n`=0, `sram_be_n`=~latched `byte_en`.
  - `sram_dq` is driven with the latched data.
- WREC:
  - Lasts 1 cycle.
  - `sram_we_n`=1, and `sram_dq` stays driven for hold time.
  - Then go to DONE.
- READ:
  - Lasts `BEATS*WAIT_STATES` cycles.
  - `sram_oe_n`=0, `sram_ce_n`=0, `sram_be_n`=0.
  - Beat b presents address `word+b`, which wraps modulo 2^`SRAM_AW`.
  - On the last cycle of beat b, `sram_dq` is sampled into `read_data[b*DW +: DW]`.
- DONE:
  - Lasts 1 cycle; `ready`=1; then go to IDLE.
  - A request still asserted in the following IDLE cycle starts a new transaction.
- `ready = (IDLE && !mem_w_en && !mem_r_en) || DONE`.
  - `ready` is forced to 0 while `rst` is high.
- `sram_dq` is high-Z in every state except WRITE and WREC.
- `sram_ce_n`=1, `sram_oe_n`=1, `sram_we_n`=1 and `sram_be_n`=all-1 in IDLE and DONE.
- `read_data` holds its value until the next read completes its beats. Writes never alter it.
- A change of `mem_*_en` or `address` mid-transaction is ignored, because all operands are latched.

## Timing
- Reset values, applied at the first `rst` edge:
  - state = IDLE.
  - `read_data` = 0, `sram_addr` = 0.
  - `sram_we_n`, `sram_oe_n`, `sram_ce_n` = 1; `sram_be_n` = all-1.
  - `sram_dq` = Z; `addr_err` = 0.
- Latency is counted from cycle 0, the IDLE cycle that accepts the request:
  - Write: WRITE occupies cycles 1..`WAIT_STATES`, WREC follows, and `ready`=1 in cycle `WAIT_STATES`+2. With defaults, `ready` rises in cycle 5.
  - Read: `ready`=1 in cycle `BEATS*WAIT_STATES`+1. With defaults, `ready` rises in cycle 7.
- Reset mid-operation: at the next edge the state is IDLE and `sram_we_n`=1. `sram_dq` is released in the same cycle `rst` is sampled, and `read_data` is cleared. No partial line is kept.
- `sram_addr` is registered. It changes only at beat boundaries and holds its last value in IDLE and DONE.

## Configuration
- `SRAM_CTRL_RANGE_CHK_EN` defined:
  - A request is out of range when `address < BASE_ADDR` or `address - BASE_ADDR ≥ 2^SRAM_AW * DW/8`.
  - An out-of-range request goes IDLE→DONE with no SRAM strobe asserted.
  - `addr_err`=1 during that DONE cycle, so `ready` rises in cycle 1.
  - `read_data` is unchanged.
- `SRAM_CTRL_RANGE_CHK_EN` undefined:
  - The `addr_err` port is absent.
  - Offsets are truncated modulo the SRAM size and every request accesses SRAM.

## Test plan
- Write, with defaults: `address`=0x410, `write_data`=0xDEADBEEF, `byte_en`=0xF.
  - `sram_addr`=4.
  - `sram_we_n` low in cycles 1–3, with `sram_dq`=0xDEADBEEF in cycles 1–4.
  - `ready` high in cycle 5 only.
- Line read: write 0x12345678 to 0x414, then read 0x410.
  - `sram_oe_n` low in cycles 1–6.
  - `sram_addr` is 4 in cycles 1–3 and 5 in cycles 4–6.
  - `read_data`=64'h12345678_DEADBEEF in cycle 7, with `ready`=1.
- Byte lanes: write with `byte_en`=4'b0011 → `sram_be_n`=4'b1100 during WRITE and WREC.
- Simultaneous requests: `mem_w_en`=`mem_r_en`=1 → write sequence executes, `sram_oe_n` stays 1, and `ready` rises in cycle 5.
- Reset mid-read: `rst` in cycle 3 of a read.
  - Next cycle: IDLE, `read_data`=0, `sram_oe_n`=1, `sram_dq`=Z.
  - `ready`=1 once `rst` and the requests are low.
- With `SRAM_CTRL_RANGE_CHK_EN`: read of `address`=0x100.
  - `ready` and `addr_err` are 1 in cycle 1.
  - `sram_ce_n` never goes low, and `read_data` is unchanged.

Source files
------------

// File: rtl/sram_ctrl_gen_if.sv
// CPU-side request/response bundle for sram_ctrl_gen.
// The addr_err signal exists only when SRAM_CTRL_RANGE_CHK_EN is defined.
interface sram_ctrl_gen_if #(
    parameter int unsigned DW    = 32,
    parameter int unsigned BEATS = 2
);
    logic                  mem_w_en;
    logic                  mem_r_en;
    logic [31:0]           address;
    logic [DW-1:0]         write_data;
    logic [DW/8-1:0]       byte_en;
    logic                  ready;
    logic [DW*BEATS-1:0]   read_data;
`ifdef SRAM_CTRL_RANGE_CHK_EN
    logic                  addr_err;

    modport master (
        output mem_w_en, mem_r_en, address, write_data, byte_en,
        input  ready, read_data, addr_err
    );
    modport slave (
        input  mem_w_en, mem_r_en, address, write_data, byte_en,
        output ready, read_data, addr_err
    );
`else
    modport master (
        output mem_w_en, mem_r_en, address, write_data, byte_en,
        input  ready, read_data
    );
    modport slave (
        input  mem_w_en, mem_r_en, address, write_data, byte_en,
        output ready, read_data
    );
`endif
endinterface

// File: rtl/sram_ctrl_gen.sv
// External async-SRAM controller: wait-stated byte-lane writes and multi-beat line reads.
// Optional macro SRAM_CTRL_RANGE_CHK_EN adds out-of-range rejection and the addr_err output.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for mem_w_en / mem_r_en, operands latched on accept
// WRITE   | we_n/ce_n low, dq driven, WAIT_STATES cycles
// WREC    | we_n released, dq held one cycle for hold time
// READ    | oe_n/ce_n low, BEATS beats of WAIT_STATES cycles each
// DONE    | ready pulse, back to IDLE
module sram_ctrl_gen #(
    parameter int unsigned DW          = 32,
    parameter int unsigned SRAM_AW     = 17,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_STATES = 3,
    parameter int unsigned BEATS       = 2
) (
    input  logic                clk,
    input  logic                rst,
    sram_ctrl_gen_if.slave      bus,
    output logic [SRAM_AW-1:0]  o_sram_addr,
    inout  wire  [DW-1:0]       io_sram_dq,
    output logic                o_sram_we_n,
    output logic                o_sram_oe_n,
    output logic                o_sram_ce_n,
    output logic [DW/8-1:0]     o_sram_be_n
);
    localparam int unsigned LANES     = DW / 8;
    localparam int unsigned LANE_BITS = $clog2(LANES);
    localparam int unsigned CW        = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam int unsigned BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_STATES - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_WREC  = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]          r_state;
    logic [SRAM_AW-1:0]  r_sram_addr;
    logic [CW-1:0]       r_wait;
    logic [BW-1:0]       r_beat;
    logic [DW-1:0]       r_wdata;
    logic [LANES-1:0]    r_be;
    logic [DW*BEATS-1:0] r_line;
    logic [DW*BEATS-1:0] r_read_data;

    logic [DW*BEATS-1:0] w_line_next;
    logic [31:0]         w_offset;
    logic [31:0]         w_word_full;
    logic [SRAM_AW-1:0]  w_word;
    logic                w_req;
    logic                w_accept;
    logic                w_skip;
    logic                w_dq_oe;
    logic                w_unused;

    assign w_req       = bus.mem_w_en | bus.mem_r_en;
    assign w_accept    = (r_state == S_IDLE) && w_req;
    assign w_offset    = bus.address - BASE_ADDR;
    assign w_word_full = w_offset >> LANE_BITS;
    assign w_word      = w_word_full[SRAM_AW-1:0];
    // upper offset bits only matter to the optional range check
    assign w_unused    = ^w_word_full;

`ifdef SRAM_CTRL_RANGE_CHK_EN
    logic r_addr_err;
    logic w_oor;

    assign w_oor  = (bus.address < BASE_ADDR) || ((w_word_full >> SRAM_AW) != 32'd0);
    assign w_skip = w_oor;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= w_accept && w_oor;
        end
    end

    assign bus.addr_err = r_addr_err;
`else
    assign w_skip = 1'b0;
`endif

    always_comb begin
        w_line_next = r_line;
        for (int b = 0; b < int'(BEATS); b++) begin
            if (r_beat == BW'(b)) begin
                w_line_next[b*DW +: DW] = io_sram_dq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sram_addr <= '0;
            r_wait      <= '0;
            r_beat      <= '0;
            r_line      <= '0;
            r_read_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_skip) begin
                            r_state <= S_DONE;
                        end else begin
                            r_sram_addr <= w_word;
                            r_wait      <= WAIT_LAST;
                            r_beat      <= '0;
                            r_state     <= bus.mem_w_en ? S_WRITE : S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    if (r_wait == '0) begin
                        r_state <= S_WREC;
                    end else begin
                        r_wait <= r_wait - CW'(1);
                    end
                end
                S_WREC: begin
                    r_state <= S_DONE;
                end
                S_READ: begin
                    if (r_wait == '0) begin
                        r_line <= w_line_next;
                        if (r_beat == BEAT_LAST) begin
                            // publish the whole line at once so read_data never shows a partial line
                            r_read_data <= w_line_next;
                            r_state     <= S_DONE;
                        end else begin
                            r_beat      <= r_beat + BW'(1);
                            r_sram_addr <= r_sram_addr + SRAM_AW'(1);
                            r_wait      <= WAIT_LAST;
                        end
                    end else begin
                        r_wait <= r_wait - CW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_wdata <= bus.write_data;
            r_be    <= bus.byte_en;
        end
    end

    always_comb begin
        o_sram_we_n = 1'b1;
        o_sram_oe_n = 1'b1;
        o_sram_ce_n = 1'b1;
        o_sram_be_n = '1;
        case (r_state)
            S_WRITE: begin
                o_sram_we_n = 1'b0;
                o_sram_ce_n = 1'b0;
                o_sram_be_n = ~r_be;
            end
            S_WREC: begin
                o_sram_ce_n = 1'b0;
                o_sram_be_n = ~r_be;
            end
            S_READ: begin
                o_sram_oe_n = 1'b0;
                o_sram_ce_n = 1'b0;
                o_sram_be_n = '0;
            end
            default: begin
                o_sram_we_n = 1'b1;
            end
        endcase
    end

    // bus is released combinationally as soon as rst is seen
    assign w_dq_oe     = !rst && ((r_state == S_WRITE) || (r_state == S_WREC));
    assign io_sram_dq  = w_dq_oe ? r_wdata : {DW{1'bz}};
    assign o_sram_addr = r_sram_addr;

    assign bus.ready     = !rst && (((r_state == S_IDLE) && !w_req) || (r_state == S_DONE));
    assign bus.read_data = r_read_data;
endmodule

// File: tb/tb_sram_ctrl_gen.sv
// Directed bench for sram_ctrl_gen: per-cycle pin checks against hand-computed timing.
// Exercises the range-check path only when SRAM_CTRL_RANGE_CHK_EN is defined.
module tb_sram_ctrl_gen;
    localparam int MAXC = 16;

    logic        clk;
    logic        rst;
    logic [16:0] sram_addr;
    wire  [31:0] sram_dq;
    logic        sram_we_n, sram_oe_n, sram_ce_n;
    logic [3:0]  sram_be_n;
    logic        probe_en;

    int n_checks;
    int n_fail;
    int n_cyc;

    logic [31:0] mem [0:255];

    logic        rec_we   [0:MAXC-1];
    logic        rec_oe   [0:MAXC-1];
    logic        rec_ce   [0:MAXC-1];
    logic        rec_rdy  [0:MAXC-1];
    logic [3:0]  rec_be   [0:MAXC-1];
    logic [16:0] rec_addr [0:MAXC-1];
    logic [31:0] rec_dq   [0:MAXC-1];
    logic [63:0] rec_rd   [0:MAXC-1];
    logic        rec_err  [0:MAXC-1];

    sram_ctrl_gen_if #(.DW(32), .BEATS(2)) bus ();

    sram_ctrl_gen dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_sram_addr (sram_addr),
        .io_sram_dq  (sram_dq),
        .o_sram_we_n (sram_we_n),
        .o_sram_oe_n (sram_oe_n),
        .o_sram_ce_n (sram_ce_n),
        .o_sram_be_n (sram_be_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // small SRAM model, aliased on the low 8 address bits
    assign sram_dq = (!sram_oe_n && !sram_ce_n) ? mem[sram_addr[7:0]] : 32'bz;
    assign sram_dq = probe_en ? 32'h0 : 32'bz;

    always @(posedge clk) begin
        if (!sram_we_n && !sram_ce_n) begin
            for (int i = 0; i < 4; i++) begin
                if (!sram_be_n[i]) mem[sram_addr[7:0]][8*i +: 8] <= sram_dq[8*i +: 8];
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input logic w, input logic r, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be);
        @(posedge clk);
        #1;
        bus.mem_w_en   = w;
        bus.mem_r_en   = r;
        bus.address    = a;
        bus.write_data = d;
        bus.byte_en    = be;
        n_cyc = -1;
        for (int k = 0; k < MAXC; k++) begin
            @(negedge clk);
            rec_we[k]   = sram_we_n;
            rec_oe[k]   = sram_oe_n;
            rec_ce[k]   = sram_ce_n;
            rec_rdy[k]  = bus.ready;
            rec_be[k]   = sram_be_n;
            rec_addr[k] = sram_addr;
            rec_dq[k]   = sram_dq;
            rec_rd[k]   = bus.read_data;
`ifdef SRAM_CTRL_RANGE_CHK_EN
            rec_err[k]  = bus.addr_err;
`else
            rec_err[k]  = 1'b0;
`endif
            if (bus.ready) begin
                n_cyc = k;
                bus.mem_w_en = 1'b0;
                bus.mem_r_en = 1'b0;
                break;
            end
        end
        check_val("txn_completed", 64'(n_cyc >= 0), 64'd1);
    endtask

    task automatic check_write(input string t, input logic [16:0] a0, input logic [31:0] d,
                               input logic [3:0] be_n_exp);
        check_val({t, "_cycles"}, 64'(n_cyc), 64'd5);
        for (int k = 0; k <= 5; k++) begin
            check_val($sformatf("%s_ready_c%0d", t, k), 64'(rec_rdy[k]), 64'(k == 5));
            check_val($sformatf("%s_oe_n_c%0d", t, k), 64'(rec_oe[k]), 64'd1);
            check_val($sformatf("%s_we_n_c%0d", t, k), 64'(rec_we[k]), (k >= 1 && k <= 3) ? 64'd0 : 64'd1);
            if (k >= 1) check_val($sformatf("%s_addr_c%0d", t, k), 64'(rec_addr[k]), 64'(a0));
            if (k >= 1 && k <= 4) begin
                check_val($sformatf("%s_dq_c%0d", t, k), 64'(rec_dq[k]), 64'(d));
                check_val($sformatf("%s_be_n_c%0d", t, k), 64'(rec_be[k]), 64'(be_n_exp));
            end
            if (k >= 1 && k <= 3) check_val($sformatf("%s_ce_n_c%0d", t, k), 64'(rec_ce[k]), 64'd0);
            if (k == 0 || k == 5) begin
                check_val($sformatf("%s_ce_n_c%0d", t, k), 64'(rec_ce[k]), 64'd1);
                check_val($sformatf("%s_be_n_c%0d", t, k), 64'(rec_be[k]), 64'hF);
            end
        end
    endtask

    task automatic check_read(input string t, input logic [16:0] a0, input logic [63:0] line,
                              input logic [63:0] prev);
        logic [16:0] a1;
        a1 = a0 + 17'd1;
        check_val({t, "_cycles"}, 64'(n_cyc), 64'd7);
        for (int k = 0; k <= 7; k++) begin
            check_val($sformatf("%s_ready_c%0d", t, k), 64'(rec_rdy[k]), 64'(k == 7));
            check_val($sformatf("%s_we_n_c%0d", t, k), 64'(rec_we[k]), 64'd1);
            check_val($sformatf("%s_oe_n_c%0d", t, k), 64'(rec_oe[k]), (k >= 1 && k <= 6) ? 64'd0 : 64'd1);
            if (k >= 1) check_val($sformatf("%s_addr_c%0d", t, k), 64'(rec_addr[k]), (k <= 3) ? 64'(a0) : 64'(a1));
            if (k >= 1 && k <= 6) begin
                check_val($sformatf("%s_be_n_c%0d", t, k), 64'(rec_be[k]), 64'd0);
                check_val($sformatf("%s_rd_hold_c%0d", t, k), rec_rd[k], prev);
            end
        end
        check_val({t, "_line"}, rec_rd[7], line);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst            = 1'b1;
        probe_en       = 1'b0;
        bus.mem_w_en   = 1'b0;
        bus.mem_r_en   = 1'b0;
        bus.address    = 32'h0;
        bus.write_data = 32'h0;
        bus.byte_en    = 4'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready_forced", 64'(bus.ready), 64'd0);
        check_val("rst_we_n", 64'(sram_we_n), 64'd1);
        check_val("rst_oe_n", 64'(sram_oe_n), 64'd1);
        check_val("rst_ce_n", 64'(sram_ce_n), 64'd1);
        check_val("rst_be_n", 64'(sram_be_n), 64'hF);
        check_val("rst_addr", 64'(sram_addr), 64'd0);
        check_val("rst_read_data", bus.read_data, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("idle_ready", 64'(bus.ready), 64'd1);

        run_txn(1'b1, 1'b0, 32'h410, 32'hDEADBEEF, 4'hF);
        check_write("w1", 17'd4, 32'hDEADBEEF, 4'h0);
        check_val("w1_rd_untouched", bus.read_data, 64'd0);

        run_txn(1'b1, 1'b0, 32'h414, 32'h12345678, 4'hF);
        check_write("w2", 17'd5, 32'h12345678, 4'h0);

        run_txn(1'b0, 1'b1, 32'h410, 32'hFFFFFFFF, 4'h0);
        check_read("r1", 17'd4, 64'h12345678_DEADBEEF, 64'd0);

        run_txn(1'b1, 1'b0, 32'h418, 32'hAABBCCDD, 4'b0011);
        check_write("wbe", 17'd6, 32'hAABBCCDD, 4'b1100);
        check_val("wbe_rd_untouched", bus.read_data, 64'h12345678_DEADBEEF);

        run_txn(1'b0, 1'b1, 32'h418, 32'hFFFFFFFF, 4'h0);
        check_read("rbe", 17'd6, 64'h00000000_0000CCDD, 64'h12345678_DEADBEEF);

        run_txn(1'b1, 1'b1, 32'h41C, 32'h0BADF00D, 4'hF);
        check_write("both", 17'd7, 32'h0BADF00D, 4'h0);

        run_txn(1'b0, 1'b1, 32'h41E, 32'hFFFFFFFF, 4'h0);
        check_read("r_lowbits", 17'd7, 64'h00000000_0BADF00D, 64'h00000000_0000CCDD);

        run_txn(1'b1, 1'b0, 32'h803FC, 32'hCAFEF00D, 4'hF);
        check_write("w_top", 17'h1FFFF, 32'hCAFEF00D, 4'h0);
        run_txn(1'b1, 1'b0, 32'h400, 32'h600DD00D, 4'hF);
        check_write("w_zero", 17'h0, 32'h600DD00D, 4'h0);
        run_txn(1'b0, 1'b1, 32'h803FC, 32'hFFFFFFFF, 4'h0);
        check_read("r_wrap", 17'h1FFFF, 64'h600DD00D_CAFEF00D, 64'h00000000_0BADF00D);

        @(posedge clk);
        #1;
        bus.mem_r_en   = 1'b1;
        bus.address    = 32'h414;
        bus.write_data = 32'hFFFFFFFF;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst_ready", 64'(bus.ready), 64'd0);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.mem_r_en = 1'b0;
        @(negedge clk);
        check_val("mid_rst_read_data", bus.read_data, 64'd0);
        check_val("mid_rst_oe_n", 64'(sram_oe_n), 64'd1);
        check_val("mid_rst_ce_n", 64'(sram_ce_n), 64'd1);
        check_val("mid_rst_we_n", 64'(sram_we_n), 64'd1);
        check_val("mid_rst_ready_after", 64'(bus.ready), 64'd1);
        probe_en = 1'b1;
        @(negedge clk);
        check_val("idle_dq_released", 64'(sram_dq), 64'd0);
        probe_en = 1'b0;

        run_txn(1'b0, 1'b1, 32'h410, 32'hFFFFFFFF, 4'h0);
        check_read("r_after_rst", 17'd4, 64'h12345678_DEADBEEF, 64'd0);

`ifdef SRAM_CTRL_RANGE_CHK_EN
        check_val("inrange_addr_err", 64'(rec_err[7]), 64'd0);
        run_txn(1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'h0);
        check_val("oor_cycles", 64'(n_cyc), 64'd1);
        check_val("oor_addr_err", 64'(rec_err[1]), 64'd1);
        check_val("oor_ce_n_c0", 64'(rec_ce[0]), 64'd1);
        check_val("oor_ce_n_c1", 64'(rec_ce[1]), 64'd1);
        check_val("oor_read_data", bus.read_data, 64'h12345678_DEADBEEF);
        run_txn(1'b1, 1'b0, 32'h80400, 32'h11111111, 4'hF);
        check_val("oor_top_cycles", 64'(n_cyc), 64'd1);
        check_val("oor_top_addr_err", 64'(rec_err[1]), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
